// File: rtl/wsg_pkg.sv
// Shared types and constants for the three-voice waveform sound generator sequencer.
package wsg_pkg;

    localparam int unsigned NUM_VOICES = 3;
    localparam int unsigned ACC_W      = 20;
    localparam int unsigned MIX_W      = 10;
    localparam int unsigned WAVE_W     = 3;
    localparam int unsigned VOL_W      = 4;
    localparam int unsigned DATA_W     = 4;
    localparam int unsigned PHASE_W    = 5;
    localparam int unsigned ROM_AW     = WAVE_W + PHASE_W;

    // Voices 1 and 2 have no low frequency nibble; these bits are forced to zero.
    localparam logic [ACC_W-1:0] FREQ_LO_MASK = 20'hFFFF0;

    // One address/wait/multiply triple per voice, then a single output cycle.
    typedef enum logic [3:0] {
        StIdle,
        StA0, StW0, StM0,
        StA1, StW1, StM1,
        StA2, StW2, StM2,
        StDone
    } state_e;

    // Voice served by a given state; states outside the voice slots map to voice 0.
    function automatic logic [1:0] voice_of(state_e s);
        logic [1:0] v;
        case (s)
            StA1, StW1, StM1: v = 2'd1;
            StA2, StW2, StM2: v = 2'd2;
            default:          v = 2'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/wsg_voice_sequencer_if.sv
// Bundle of voice registers, ROM port and mix output between the sequencer and its environment.
interface wsg_voice_sequencer_if #(
    parameter int unsigned ACC_W = 20,
    parameter int unsigned MIX_W = 10
);
    import wsg_pkg::*;

    logic                 sample_tick;
    logic                 snd_en;
    logic [ACC_W-1:0]     freq0;
    logic [ACC_W-1:0]     freq1;
    logic [ACC_W-1:0]     freq2;
    logic [WAVE_W-1:0]    wave0;
    logic [WAVE_W-1:0]    wave1;
    logic [WAVE_W-1:0]    wave2;
    logic [VOL_W-1:0]     vol0;
    logic [VOL_W-1:0]     vol1;
    logic [VOL_W-1:0]     vol2;
    logic [ROM_AW-1:0]    rom_addr;
    logic                 rom_rd;
    logic [DATA_W-1:0]    rom_data;
    logic [MIX_W-1:0]     mix_out;
    logic                 mix_valid;
    logic                 busy;
    logic                 overrun;

    // Environment side: register file, tick source and waveform ROM.
    modport master (
        output sample_tick, snd_en,
        output freq0, freq1, freq2,
        output wave0, wave1, wave2,
        output vol0, vol1, vol2,
        output rom_data,
        input  rom_addr, rom_rd, mix_out, mix_valid, busy, overrun
    );

    // Sequencer side.
    modport slave (
        input  sample_tick, snd_en,
        input  freq0, freq1, freq2,
        input  wave0, wave1, wave2,
        input  vol0, vol1, vol2,
        input  rom_data,
        output rom_addr, rom_rd, mix_out, mix_valid, busy, overrun
    );

endinterface

// File: rtl/wsg_mac.sv
// 4x4 multiply with a clearable MIX_W-bit accumulator, shared by all three voices.
module wsg_mac #(
    parameter int unsigned MIX_W = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [3:0]       data_i,
    input  logic [3:0]       vol_i,
    output logic [MIX_W-1:0] sum_o
);

    logic [7:0]       prod;
    logic [MIX_W-1:0] sum_q, sum_d;

    // Next sum: clear wins over accumulate; the 8-bit product is zero-extended.
    always_comb begin
        prod  = data_i * vol_i;
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = '0;
        end else if (en_i) begin
            sum_d = sum_q + MIX_W'(prod);
        end
    end

    // Accumulator register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/wsg_voice_sequencer.sv
// Per-sample scheduler: advances three phase accumulators and mixes the voices through one ROM
// port and one MAC, producing one sample per sample_tick.
module wsg_voice_sequencer #(
    parameter int unsigned ACC_W = 20,
    parameter int unsigned MIX_W = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    wsg_voice_sequencer_if.slave bus
);
    import wsg_pkg::*;

    state_e state_q, state_d;

    logic [NUM_VOICES-1:0][ACC_W-1:0]  acc_q, acc_d;
    logic [NUM_VOICES-1:0][ACC_W-1:0]  freq_q, freq_d;
    logic [NUM_VOICES-1:0][WAVE_W-1:0] wave_q, wave_d;
    logic [NUM_VOICES-1:0][VOL_W-1:0]  vol_q, vol_d;

    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic              rom_rd_q, rom_rd_d;
    logic [MIX_W-1:0]  mix_q, mix_d;
    logic              mix_valid_q, mix_valid_d;
    logic              overrun_q, overrun_d;

    logic [1:0]        vidx;
    logic [ACC_W-1:0]  acc_next;
    logic              mac_clr;
    logic              mac_en;
    logic [MIX_W-1:0]  mac_sum;

    // Next-state, datapath updates and MAC control for the frame sequence.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        freq_d      = freq_q;
        wave_d      = wave_q;
        vol_d       = vol_q;
        rom_addr_d  = rom_addr_q;
        rom_rd_d    = 1'b0;
        mix_d       = mix_q;
        mix_valid_d = 1'b0;
        overrun_d   = overrun_q;
        mac_clr     = 1'b0;
        mac_en      = 1'b0;
        vidx        = voice_of(state_q);
        acc_next    = acc_q[vidx] + freq_q[vidx];

        // A tick arriving mid-frame is dropped, never queued.
        if (bus.sample_tick && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.sample_tick) begin
                    freq_d[0] = bus.freq0;
                    freq_d[1] = bus.freq1 & FREQ_LO_MASK;
                    freq_d[2] = bus.freq2 & FREQ_LO_MASK;
                    wave_d[0] = bus.wave0;
                    wave_d[1] = bus.wave1;
                    wave_d[2] = bus.wave2;
                    vol_d[0]  = bus.vol0;
                    vol_d[1]  = bus.vol1;
                    vol_d[2]  = bus.vol2;
                    mac_clr   = 1'b1;
                    state_d   = StA0;
                end
            end
            StA0, StA1, StA2: begin
                // Address uses the freshly advanced phase.
                acc_d[vidx] = acc_next;
                rom_addr_d  = {wave_q[vidx], acc_next[ACC_W-1 -: PHASE_W]};
                rom_rd_d    = 1'b1;
                state_d     = (state_q == StA0) ? StW0 : (state_q == StA1) ? StW1 : StW2;
            end
            StW0, StW1, StW2: begin
                state_d = (state_q == StW0) ? StM0 : (state_q == StW1) ? StM1 : StM2;
            end
            StM0, StM1, StM2: begin
                mac_en  = 1'b1;
                state_d = (state_q == StM0) ? StA1 : (state_q == StM1) ? StA2 : StDone;
            end
            StDone: begin
                mix_d       = bus.snd_en ? mac_sum : '0;
                mix_valid_d = 1'b1;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            freq_q      <= '0;
            wave_q      <= '0;
            vol_q       <= '0;
            rom_addr_q  <= '0;
            rom_rd_q    <= 1'b0;
            mix_q       <= '0;
            mix_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            freq_q      <= freq_d;
            wave_q      <= wave_d;
            vol_q       <= vol_d;
            rom_addr_q  <= rom_addr_d;
            rom_rd_q    <= rom_rd_d;
            mix_q       <= mix_d;
            mix_valid_q <= mix_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    wsg_mac #(
        .MIX_W (MIX_W)
    ) u_mac (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (mac_clr),
        .en_i   (mac_en),
        .data_i (bus.rom_data),
        .vol_i  (vol_q[vidx]),
        .sum_o  (mac_sum)
    );

    assign bus.rom_addr  = rom_addr_q;
    assign bus.rom_rd    = rom_rd_q;
    assign bus.mix_out   = mix_q;
    assign bus.mix_valid = mix_valid_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_wsg_voice_sequencer.sv
// Directed bench for the voice sequencer with a registered ROM returning rom_addr[3:0].
module tb_wsg_voice_sequencer;

    logic clk;
    logic rst;
    logic rom_force;

    int checks;
    int errors;

    // Per-frame observations.
    logic [7:0]  got_addr [3];
    int          n_rd;
    logic [15:0] rd_mask;
    int          n_valid;
    int          valid_cyc;
    logic [9:0]  got_mix;
    logic        busy_early;
    logic        busy_late;
    logic [7:0]  snap_addr;
    logic        snap_rd;
    logic [9:0]  snap_mix;
    logic        snap_valid;
    logic        snap_busy;
    logic        snap_ovr;

    wsg_voice_sequencer_if bus ();

    wsg_voice_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered waveform ROM model.
    always @(posedge clk) begin
        bus.rom_data <= rom_force ? 4'hF : bus.rom_addr[3:0];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.sample_tick = 1'b0;
        bus.snd_en      = 1'b1;
        bus.freq0       = '0;
        bus.freq1       = '0;
        bus.freq2       = '0;
        bus.wave0       = '0;
        bus.wave1       = '0;
        bus.wave2       = '0;
        bus.vol0        = '0;
        bus.vol1        = '0;
        bus.vol2        = '0;
        rom_force       = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // One tick at E0 then 14 observed cycles; optional extra tick, reset pulse and vol0 change
    // applied in the cycle ending at edge E<n>.
    task automatic run_frame(input int extra_tick, input int rst_at, input int vol_at,
                             input logic [3:0] new_vol);
        n_rd      = 0;
        rd_mask   = '0;
        n_valid   = 0;
        valid_cyc = 0;
        got_mix   = 'x;
        for (int k = 0; k < 3; k++) got_addr[k] = 'x;
        @(negedge clk);
        bus.sample_tick = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 1; i <= 14; i++) begin
            bus.sample_tick = (i == extra_tick);
            rst = (i != rst_at);
            if (i == vol_at) bus.vol0 = new_vol;
            @(posedge clk);
            @(negedge clk);
            if (bus.rom_rd) begin
                rd_mask[i] = 1'b1;
                if (n_rd < 3) got_addr[n_rd] = bus.rom_addr;
                n_rd++;
            end
            if (bus.mix_valid) begin
                n_valid++;
                valid_cyc = i;
                got_mix   = bus.mix_out;
            end
            if (i == 1) busy_early = bus.busy;
            if (i == 11) busy_late = bus.busy;
            if (i == rst_at) begin
                snap_addr  = bus.rom_addr;
                snap_rd    = bus.rom_rd;
                snap_mix   = bus.mix_out;
                snap_valid = bus.mix_valid;
                snap_busy  = bus.busy;
                snap_ovr   = bus.overrun;
            end
        end
        bus.sample_tick = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        clear_inputs();
        do_reset();

        // Reset state.
        @(negedge clk);
        check("rst_rom_addr", bus.rom_addr, 0);
        check("rst_rom_rd", bus.rom_rd, 0);
        check("rst_mix_out", bus.mix_out, 0);
        check("rst_mix_valid", bus.mix_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_overrun", bus.overrun, 0);

        // Test 1: voice 0 only, phase step of one ROM entry per frame.
        bus.freq0 = 20'h08000;
        bus.vol0  = 4'hF;
        run_frame(0, 0, 0, 4'h0);
        check("t1_f1_addr0", got_addr[0], 8'h01);
        check("t1_f1_addr1", got_addr[1], 8'h00);
        check("t1_f1_addr2", got_addr[2], 8'h00);
        check("t1_f1_rd_cycles", rd_mask, 16'h0092);
        check("t1_f1_mix", got_mix, 15);
        check("t1_f1_nvalid", n_valid, 1);
        check("t1_f1_valid_edge", valid_cyc, 10);
        check("t1_busy_early", busy_early, 1);
        check("t1_busy_late", busy_late, 0);
        check("t1_f1_overrun", bus.overrun, 0);
        run_frame(0, 0, 0, 4'h0);
        check("t1_f2_addr0", got_addr[0], 8'h02);
        check("t1_f2_mix", got_mix, 30);

        // Test 2: accumulator wraps modulo 2^20.
        clear_inputs();
        do_reset();
        bus.freq0 = 20'h80000;
        bus.vol0  = 4'hF;
        run_frame(0, 0, 0, 4'h0);
        check("t2_f1_addr0", got_addr[0], 8'h10);
        check("t2_f1_mix", got_mix, 0);
        run_frame(0, 0, 0, 4'h0);
        check("t2_f2_addr0", got_addr[0], 8'h00);
        check("t2_f2_acc0", dut.acc_q[0], 0);

        // Test 3: low nibble of voice 1 frequency is ignored.
        clear_inputs();
        do_reset();
        bus.freq1 = 20'h0000F;
        bus.vol1  = 4'hF;
        repeat (4) run_frame(0, 0, 0, 4'h0);
        check("t3_addr1", got_addr[1], 8'h00);
        check("t3_acc1", dut.acc_q[1], 0);
        check("t3_mix", got_mix, 0);

        // Test 4: full-scale mix, then the same with sound disabled.
        clear_inputs();
        do_reset();
        bus.vol0  = 4'hF;
        bus.vol1  = 4'hF;
        bus.vol2  = 4'hF;
        rom_force = 1'b1;
        run_frame(0, 0, 0, 4'h0);
        check("t4_full_scale", got_mix, 10'h2A3);
        bus.snd_en = 1'b0;
        run_frame(0, 0, 0, 4'h0);
        check("t4_snd_off_mix", got_mix, 0);
        check("t4_snd_off_nvalid", n_valid, 1);

        // Test 5a: second tick three clocks in is dropped.
        clear_inputs();
        do_reset();
        bus.freq0 = 20'h08000;
        bus.vol0  = 4'hF;
        run_frame(3, 0, 0, 4'h0);
        check("t5_ovr_nvalid", n_valid, 1);
        check("t5_ovr_flag", bus.overrun, 1);
        check("t5_ovr_mix", got_mix, 15);

        // Test 5b: reset in M1 (sampled at E6) aborts the frame.
        run_frame(0, 6, 0, 4'h0);
        check("t5_rst_busy", snap_busy, 0);
        check("t5_rst_addr", snap_addr, 0);
        check("t5_rst_rd", snap_rd, 0);
        check("t5_rst_mix", snap_mix, 0);
        check("t5_rst_valid", snap_valid, 0);
        check("t5_rst_overrun", snap_ovr, 0);
        check("t5_rst_nvalid", n_valid, 0);
        check("t5_rst_rd_cycles", rd_mask, 16'h0012);
        check("t5_rst_acc0", dut.acc_q[0], 0);

        // Test 6: vol0 change during W0 only affects the next frame.
        clear_inputs();
        do_reset();
        bus.freq0 = 20'h08000;
        bus.vol0  = 4'hF;
        run_frame(0, 0, 2, 4'h1);
        check("t6_f1_mix", got_mix, 15);
        run_frame(0, 0, 0, 4'h1);
        check("t6_f2_mix", got_mix, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wsg_voice_sequencer.md
# wsg_voice_sequencer

Per-sample scheduler for the three-voice waveform sound generator. It holds the per-voice phase accumulators and, once per `sample_tick`, lets the three voices take turns on a single shared waveform ROM port and a single 4x4 multiply-accumulate. The result is one mixed sample per tick. Voice register values (frequency, waveform select, volume) come from the CPU-written sound register file at 0x5040–0x505F. `mix_out` feeds the DAC/PWM stage.

## Interface
Parameters:
- `ACC_W`, default 20: phase accumulator width per voice.
- `MIX_W`, default 10: mix output width; 3 × 15 × 15 = 675 fits.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset. Synchronous, active-low: the block is in reset when `rst` == 0 at a `clk` rising edge.
- `sample_tick`, in, 1: one-cycle strobe that starts a frame (96 kHz rate).
- `snd_en`, in, 1: global sound enable; when 0, the sample written to `mix_out` is forced to 0.
- `freq0`, in, 20: voice 0 frequency; all 20 bits are used.
- `freq1`, in, 20: voice 1 frequency; bits [3:0] are ignored and treated as 0.
- `freq2`, in, 20: voice 2 frequency; bits [3:0] are ignored and treated as 0.
- `wave0`, `wave1`, `wave2`, in, 3 each: waveform select per voice.
- `vol0`, `vol1`, `vol2`, in, 4 each: volume per voice.
- `rom_addr`, out, 8: waveform ROM address, {wave, acc[19:15]}. Registered.
- `rom_rd`, out, 1: ROM read strobe, high one cycle per voice.
- `rom_data`, in, 4: ROM data; valid the cycle after the cycle in which `rom_addr` is presented (state W).
- `mix_out`, out, `MIX_W`: mixed sample; holds its value between updates.
- `mix_valid`, out, 1: one-cycle pulse when `mix_out` updates.
- `busy`, out, 1: high whenever the state is not IDLE.
- `overrun`, out, 1: sticky flag; set when a tick is dropped, cleared only by reset.

## Operation
- FSM states: IDLE, A0, W0, M0, A1, W1, M1, A2, W2, M2, DONE.
- IDLE: on `sample_tick`, snapshot all `freq`/`wave`/`vol` inputs into shadow registers, clear `sum`, go to A0. CPU writes made after the snapshot affect only the next frame.
- Av:
  - `acc_v` <= `acc_v` + `freq_v`, modulo 2^20, wrapping silently.
  - `rom_addr` <= {`wave_v`, (`acc_v` + `freq_v`)[19:15]}, i.e. the address uses the updated phase.
  - `rom_rd` <= 1.
  - Go to Wv.
- Wv: `rom_rd` deasserts; the ROM samples the address. Go to Mv.
- Mv: `sum` <= `sum` + `rom_data` × `vol_v` (8-bit product, zero-extended into the 10-bit sum). Go to A(v+1), or to DONE after voice 2.
- DONE: `mix_out` <= (`snd_en` ? `sum` : 0); `mix_valid` <= 1; go to IDLE.
- Accumulators advance every frame regardless of `snd_en`.
- `sample_tick` seen in any state other than IDLE (DONE included) is ignored and sets `overrun`. No frame is queued.
- Reset, including mid-frame:
  - State goes to IDLE.
  - All accumulators, shadow registers, `sum`, `mix_out`, `rom_addr` reset to 0.
  - `rom_rd`, `mix_valid`, `busy`, `overrun` reset to 0.
  - No `mix_valid` is produced for the interrupted frame.

## Timing
- Edge E0 samples `sample_tick` in IDLE. `busy` is high from E0 until the edge that returns the FSM to IDLE.
- `rom_rd` is high in the cycles after E1, E4 and E7 (voices 0, 1, 2).
- `mix_out` and `mix_valid` update at E10; `mix_valid` is high for exactly one cycle.
- A tick sampled at E11 or later starts a new frame. Minimum tick spacing is 11 clocks.

## Structure
- Package `wsg_pkg` holds:
  - the state enum;
  - `NUM_VOICES` = 3, `ACC_W`, `MIX_W`, `WAVE_W` = 3, `VOL_W` = 4;
  - the mask for the forced-zero low nibble on voices 1 and 2.
- One sub-module, `wsg_mac`: the 4-bit × 4-bit multiply plus `MIX_W` accumulate with a clear input, driven by the FSM.

## Test plan
Bench ROM model: registered, returns `rom_data` = `rom_addr`[3:0].
1. Basic voice 0: `freq0` = 0x08000, `wave0` = 0, `vol0` = 0xF, other volumes 0, `snd_en` = 1.
   - Tick 1 → `rom_addr` 0x01, `mix_out` = 15, `mix_valid` at E10.
   - Tick 2 → `rom_addr` 0x02, `mix_out` = 30.
2. Accumulator wrap: `freq0` = 0x80000.
   - Tick 1 → `rom_addr` 0x10, `mix_out` 0.
   - Tick 2 → `acc0` wraps to 0, `rom_addr` 0x00.
3. Low-nibble masking: `freq1` = 0x0000F, `vol1` = 0xF.
   - After 4 ticks `acc1` stays 0 and `rom_addr` for voice 1 stays 0x00.
4. Full scale: all voices `wave` = 0 and `vol` = 0xF, ROM forced to 0xF → `mix_out` = 675 (0x2A3). With `snd_en` = 0 → `mix_out` = 0, `mix_valid` still pulses.
5. Overrun and mid-frame reset:
   - Second tick 3 clocks after the first → one `mix_valid` only, `overrun` = 1.
   - Assert `rst` low in state M1 → next cycle IDLE, all outputs 0, no `mix_valid`.
6. Snapshot: change `vol0` from 0xF to 0x1 during W0 → that frame uses 0xF; the next frame uses 0x1.
